// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
// The optional burst mode is selected with FIFO_WR_ARB_BURST_EN in fifo_wr_arbiter.
package fifo_wr_arb_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } arb_state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int GNT_W          = $clog2(DEF_NUM_REQ);
   localparam int ENT_W          = $clog2(DEF_FIFO_DEPTH) + 1;

   function automatic int gnt_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic int ent_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational rotate-priority picker: first set request after ptr, wrapping.
module fifo_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int               j;
   logic [IDX_W-1:0] jj;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      jj  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j  = (int'(ptr) + k) % NUM_REQ;
         jj = IDX_W'(j);
         if (!any && req[jj]) begin
            any     = 1'b1;
            idx     = jj;
            gnt[jj] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter / flush sequencer in front of the shared FIFO.
// Define FIFO_WR_ARB_BURST_EN to let a winner hold the grant for up to BURST_LEN transfers.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ctrl_en,
   input  logic                          flush_req,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [$clog2(FIFO_DEPTH):0]   fifo_entry,
   output logic                          fifo_wr_enb,
   output logic [FIFO_WIDTH-1:0]         fifo_wdata,
   output logic                          fifo_en,
   output logic                          fifo_reset,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int GW = gnt_w(NUM_REQ);
   localparam int EW = ent_w(FIFO_DEPTH);
   localparam logic [EW:0] DEPTH_V = (EW+1)'(FIFO_DEPTH);

   arb_state_e         state, state_nxt;
   logic               rst_nxt;
   logic [GW-1:0]      rr_ptr, win, pick_idx;
   logic [NUM_REQ-1:0] pick_gnt, win_oh;
   logic               pick_any, win_any;
   logic [EW:0]        occ;
   logic               space_ok, arb_ok, xfer;

   fifo_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(GW)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // The write registered last cycle is not yet in fifo_entry, so count it here.
   assign occ      = {1'b0, fifo_entry} + {{EW{1'b0}}, fifo_wr_enb};
   assign space_ok = occ < DEPTH_V;
   assign arb_ok   = !reset && ctrl_en && (state == ST_RUN) && space_ok;
   assign req_ready = arb_ok ? win_oh : '0;
   assign xfer      = arb_ok && win_any;
   assign busy      = (state != ST_RUN) || fifo_wr_enb;

`ifdef FIFO_WR_ARB_BURST_EN
   logic          lock_vld, hold;
   logic [GW-1:0] lock_id;
   logic [2:0]    burst_cnt, cnt_nxt;

   assign hold    = lock_vld && req_valid[lock_id];
   assign win     = hold ? lock_id : pick_idx;
   assign win_oh  = hold ? (NUM_REQ'(1) << lock_id) : pick_gnt;
   assign win_any = hold || pick_any;
   assign cnt_nxt = (lock_vld && (win == lock_id)) ? burst_cnt + 3'd1 : 3'd1;

   // A space stall leaves lock and count untouched; only valid-low, count or FSM exit release.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_vld  <= 1'b0;
         lock_id   <= '0;
         burst_cnt <= '0;
      end else if (state != ST_RUN || state_nxt != ST_RUN) begin
         lock_vld <= 1'b0;
      end else if (xfer) begin
         burst_cnt <= cnt_nxt;
         lock_id   <= win;
         lock_vld  <= cnt_nxt < 3'(BURST_LEN);
      end else if (lock_vld && !req_valid[lock_id]) begin
         lock_vld <= 1'b0;
      end
   end
`else
   assign win     = pick_idx;
   assign win_oh  = pick_gnt;
   assign win_any = pick_any;
`endif

   always_comb begin
      state_nxt = state;
      rst_nxt   = 1'b0;
      case (state)
         ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
         ST_DRAIN: if (!fifo_wr_enb) begin
            state_nxt = ST_FLUSH;
            rst_nxt   = 1'b1;
         end
         ST_FLUSH: state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RUN;
         rr_ptr      <= GW'(NUM_REQ - 1);
         fifo_wr_enb <= 1'b0;
         fifo_wdata  <= '0;
         fifo_en     <= 1'b0;
         fifo_reset  <= 1'b0;
         grant_id    <= '0;
      end else begin
         state       <= state_nxt;
         fifo_en     <= ctrl_en;
         fifo_reset  <= rst_nxt;
         fifo_wr_enb <= xfer;
         if (xfer) begin
            rr_ptr     <= win;
            grant_id   <= win;
            fifo_wdata <= req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
         end
      end
   end

endmodule
